// File: rtl/mpu_load.sv
// Load stage of the MPU: accepts a row-major stream of FP elements over valid/ready
// and writes each one into the matrix register file with its (i,j) location.
module mpu_load #(
   parameter int FP              = 32,
   parameter int MBITS           = 3,
   parameter int NBITS           = 3,
   parameter int MATRIX_REG_SIZE = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load_en_in,
   input  logic [MATRIX_REG_SIZE-1:0] load_addr_in,
   input  logic [MBITS:0]             mem_m_load_size_in,
   input  logic [NBITS:0]             mem_n_load_size_in,
   input  logic [FP-1:0]              mem_load_element_in,
   input  logic                       mem_load_valid_in,
   output logic                       mem_load_ready_out,
   output logic                       reg_load_en_out,
   output logic [FP-1:0]              reg_element_out,
   output logic [MBITS:0]             reg_i_load_loc_out,
   output logic [NBITS:0]             reg_j_load_loc_out,
   output logic [MATRIX_REG_SIZE-1:0] reg_load_addr_out,
   output logic [MBITS:0]             reg_m_load_size_out,
   output logic [NBITS:0]             reg_n_load_size_out,
   output logic                       reg_load_complete_out,
   output logic                       load_busy_out,
   output logic                       load_error_out
);

   typedef enum logic [1:0] {
      LOAD_IDLE   = 2'd0,
      LOAD_MATRIX = 2'd1,
      LOAD_DONE   = 2'd2
   } state_t;

   localparam logic [MBITS:0] M_ONE = {{MBITS{1'b0}}, 1'b1};
   localparam logic [NBITS:0] N_ONE = {{NBITS{1'b0}}, 1'b1};

   state_t                     state_q, state_d;
   logic [MBITS:0]             row_q, row_d;
   logic [NBITS:0]             col_q, col_d;
   logic [MBITS:0]             m_q, m_d;
   logic [NBITS:0]             n_q, n_d;
   logic [MATRIX_REG_SIZE-1:0] addr_q, addr_d;
   logic [FP-1:0]              elem_q, elem_d;
   logic [MBITS:0]             i_q, i_d;
   logic [NBITS:0]             j_q, j_d;
   logic                       ready_q, ready_d;
   logic                       wr_en_q, wr_en_d;
   logic                       complete_q, complete_d;
   logic                       busy_q, busy_d;
   logic                       error_q, error_d;

   logic transfer;
   logic last_col;
   logic last_row;
   logic size_zero;

   // Full-width compares keep M = 2^MBITS (and N = 2^NBITS) representable.
   assign transfer  = (state_q == LOAD_MATRIX) && ready_q && mem_load_valid_in;
   assign last_col  = (col_q == (n_q - N_ONE));
   assign last_row  = (row_q == (m_q - M_ONE));
   assign size_zero = (mem_m_load_size_in == '0) || (mem_n_load_size_in == '0);

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      m_d        = m_q;
      n_d        = n_q;
      addr_d     = addr_q;
      elem_d     = elem_q;
      i_d        = i_q;
      j_d        = j_q;
      ready_d    = 1'b0;
      wr_en_d    = 1'b0;
      complete_d = 1'b0;
      busy_d     = 1'b0;
      error_d    = 1'b0;

      unique case (state_q)
         LOAD_IDLE: begin
            if (load_en_in) begin
               if (size_zero) begin
                  error_d = 1'b1;
               end else begin
                  m_d     = mem_m_load_size_in;
                  n_d     = mem_n_load_size_in;
                  addr_d  = load_addr_in;
                  row_d   = '0;
                  col_d   = '0;
                  state_d = LOAD_MATRIX;
                  ready_d = 1'b1;
                  busy_d  = 1'b1;
               end
            end
         end

         LOAD_MATRIX: begin
            busy_d  = 1'b1;
            ready_d = 1'b1;
            if (transfer) begin
               wr_en_d = 1'b1;
               elem_d  = mem_load_element_in;
               i_d     = row_q;
               j_d     = col_q;
               if (last_col) begin
                  col_d = '0;
                  if (last_row) begin
                     // Drop ready immediately so no element beyond (M-1,N-1) is consumed.
                     row_d   = '0;
                     state_d = LOAD_DONE;
                     ready_d = 1'b0;
                  end else begin
                     row_d = row_q + M_ONE;
                  end
               end else begin
                  col_d = col_q + N_ONE;
               end
            end
         end

         LOAD_DONE: begin
            complete_d = 1'b1;
            state_d    = LOAD_IDLE;
         end

         default: begin
            state_d = LOAD_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= LOAD_IDLE;
         row_q      <= '0;
         col_q      <= '0;
         m_q        <= '0;
         n_q        <= '0;
         addr_q     <= '0;
         elem_q     <= '0;
         i_q        <= '0;
         j_q        <= '0;
         ready_q    <= 1'b0;
         wr_en_q    <= 1'b0;
         complete_q <= 1'b0;
         busy_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         m_q        <= m_d;
         n_q        <= n_d;
         addr_q     <= addr_d;
         elem_q     <= elem_d;
         i_q        <= i_d;
         j_q        <= j_d;
         ready_q    <= ready_d;
         wr_en_q    <= wr_en_d;
         complete_q <= complete_d;
         busy_q     <= busy_d;
         error_q    <= error_d;
      end
   end

   assign mem_load_ready_out    = ready_q;
   assign reg_load_en_out       = wr_en_q;
   assign reg_element_out       = elem_q;
   assign reg_i_load_loc_out    = i_q;
   assign reg_j_load_loc_out    = j_q;
   assign reg_load_addr_out     = addr_q;
   assign reg_m_load_size_out   = m_q;
   assign reg_n_load_size_out   = n_q;
   assign reg_load_complete_out = complete_q;
   assign load_busy_out         = busy_q;
   assign load_error_out        = error_q;

endmodule
